// File: rtl/branch_lut_loader_if.sv
// Byte-stream input and table write-port bundle for the branch LUT loader.
interface branch_lut_loader_if #(
    parameter int IDX_W  = 8,
    parameter int ADDR_W = 10
);
    logic              start;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              wr_en;
    logic [IDX_W-1:0]  wr_index;
    logic [ADDR_W-1:0] wr_data;
    logic              busy;
    logic              done;
    logic              error;

    // Byte source / controller side
    modport master (
        output start, in_valid, in_data,
        input  in_ready, wr_en, wr_index, wr_data, busy, done, error
    );

    // Loader side
    modport slave (
        input  start, in_valid, in_data,
        output in_ready, wr_en, wr_index, wr_data, busy, done, error
    );
endinterface

// File: rtl/branch_lut_loader.sv
// Sequential writer for the branch-target lookup table.
// Stream: header H, then H+1 entries of {low byte, high byte}; each entry
// becomes one write to consecutive table indices starting at 0.
module branch_lut_loader #(
    parameter int IDX_W  = 8,
    parameter int ADDR_W = 10
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    branch_lut_loader_if.slave   bus
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR  = 3'd1,
        ST_LO   = 3'd2,
        ST_HI   = 3'd3,
        ST_DONE = 3'd4,
        ST_ERR  = 3'd5
    } state_t;

    state_t            r_state;
    logic [IDX_W-1:0]  r_count;
    logic [IDX_W-1:0]  r_index;
    logic [7:0]        r_lo;
    logic              r_in_ready;
    logic              r_wr_en;
    logic [IDX_W-1:0]  r_wr_index;
    logic [ADDR_W-1:0] r_wr_data;
    logic              r_busy;
    logic              r_done;
    logic              r_error;

    logic              w_accept;

    // A high byte is legal when no bit above the target width is set.
    function automatic logic hi_byte_legal(input logic [7:0] b);
        hi_byte_legal = ((b >> (ADDR_W - 8)) == 8'h00);
    endfunction

    assign w_accept = bus.in_valid && r_in_ready;

    // Load FSM; in_ready/busy are registered alongside the state so they
    // depend on state only and flip on the same edge as the transition.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state    <= ST_IDLE;
            r_count    <= '0;
            r_index    <= '0;
            r_lo       <= 8'h00;
            r_in_ready <= 1'b0;
            r_wr_en    <= 1'b0;
            r_wr_index <= '0;
            r_wr_data  <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            r_wr_en <= 1'b0;
            case (r_state)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (bus.start) begin
                        r_state    <= ST_HDR;
                        r_index    <= '0;
                        r_done     <= 1'b0;
                        r_error    <= 1'b0;
                        r_in_ready <= 1'b1;
                        r_busy     <= 1'b1;
                    end else begin
                        r_state <= r_state;
                    end
                end
                ST_HDR: begin
                    if (w_accept) begin
                        r_count <= bus.in_data[IDX_W-1:0];
                        r_state <= ST_LO;
                    end else begin
                        r_state <= ST_HDR;
                    end
                end
                ST_LO: begin
                    if (w_accept) begin
                        r_lo    <= bus.in_data;
                        r_state <= ST_HI;
                    end else begin
                        r_state <= ST_LO;
                    end
                end
                ST_HI: begin
                    if (w_accept) begin
                        if (!hi_byte_legal(bus.in_data)) begin
                            r_state    <= ST_ERR;
                            r_error    <= 1'b1;
                            r_in_ready <= 1'b0;
                            r_busy     <= 1'b0;
                        end else begin
                            r_wr_en    <= 1'b1;
                            r_wr_index <= r_index;
                            r_wr_data  <= {bus.in_data[ADDR_W-9:0], r_lo};
                            if (r_index == r_count) begin
                                r_state    <= ST_DONE;
                                r_done     <= 1'b1;
                                r_in_ready <= 1'b0;
                                r_busy     <= 1'b0;
                            end else begin
                                r_state <= ST_LO;
                                r_index <= r_index + IDX_W'(1);
                            end
                        end
                    end else begin
                        r_state <= ST_HI;
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_in_ready <= 1'b0;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready = r_in_ready;
    assign bus.wr_en    = r_wr_en;
    assign bus.wr_index = r_wr_index;
    assign bus.wr_data  = r_wr_data;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.error    = r_error;

endmodule
